// File: rtl/polirv_pkg.sv
// Shared types and constants for the polirv unified-memory arbiter.
package polirv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_e;

    localparam int DW_OFFSET_BITS = 3;
    localparam int HALF_SEL_BIT   = 2;

    function automatic logic [31:0] half_sel(input logic [63:0] dw, input logic hi);
        return hi ? dw[63:32] : dw[31:0];
    endfunction

endpackage

// File: rtl/polirv_wait_timer.sv
// Wait-state counter for one memory access; saturates at MAX_WAIT and flags it.
module polirv_wait_timer
    import polirv_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == CNT_W'(MAX_WAIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/polirv_mem_arbiter.sv
// Arbitrates fetch and data ports onto one 64-bit single-port memory with
// alternating priority, a wait-state timeout and registered handshake outputs.
module polirv_mem_arbiter
    import polirv_pkg::*;
#(
    parameter int ADDR_BITS = 9,
    parameter int MAX_WAIT  = 15
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_req,
    input  logic [ADDR_BITS-1:0]            i_addr,
    output logic [31:0]                     i_rdata,
    output logic                            i_ack,
    input  logic                            d_req,
    input  logic                            d_we,
    input  logic [ADDR_BITS-1:0]            d_addr,
    input  logic [63:0]                     d_wdata,
    output logic [63:0]                     d_rdata,
    output logic                            d_ack,
    output logic                            m_req,
    output logic                            m_we,
    output logic [ADDR_BITS-DW_OFFSET_BITS-1:0] m_addr,
    output logic [63:0]                     m_wdata,
    input  logic [63:0]                     m_rdata,
    input  logic                            m_ready,
    output logic                            err,
    output logic                            busy
);

    localparam int DW_BITS = ADDR_BITS - DW_OFFSET_BITS;

    state_e             state_q, state_d;
    gnt_e               gnt_q, gnt_d, last_q, last_d;
    logic [DW_BITS-1:0] dw_q, dw_d;
    logic               half_q, half_d;
    logic               we_q, we_d;
    logic [63:0]        wdata_q, wdata_d;
    logic [31:0]        i_rdata_q, i_rdata_d;
    logic [63:0]        d_rdata_q, d_rdata_d;
    logic               i_ack_q, i_ack_d, d_ack_q, d_ack_d;
    logic               m_req_q, m_req_d, m_we_q, m_we_d;
    logic               err_q, err_d, busy_q, busy_d;
    logic               fail, pick_d, tmr_clear, tmr_en, tmr_expired;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^i_addr[HALF_SEL_BIT-1:0];

    polirv_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        dw_d      = dw_q;
        half_d    = half_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        fail      = 1'b0;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        // D wins when alone, or when contested and I was served last.
        pick_d    = d_req && (!i_req || last_q == GNT_I);

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    gnt_d     = pick_d ? GNT_D : GNT_I;
                    last_d    = pick_d ? GNT_D : GNT_I;
                    tmr_clear = 1'b1;
                    state_d   = ACCESS;
                    if (pick_d) begin
                        dw_d    = d_addr[ADDR_BITS-1:DW_OFFSET_BITS];
                        half_d  = d_addr[HALF_SEL_BIT];
                        we_d    = d_we;
                        wdata_d = d_wdata;
                        if (|d_addr[DW_OFFSET_BITS-1:0]) begin
                            state_d = RESP;
                            fail    = 1'b1;
                        end
                    end else begin
                        dw_d   = i_addr[ADDR_BITS-1:DW_OFFSET_BITS];
                        half_d = i_addr[HALF_SEL_BIT];
                        we_d   = 1'b0;
                    end
                end
            end
            ACCESS: begin
                if (m_ready) begin
                    state_d = RESP;
                    if (gnt_q == GNT_I) begin
                        i_rdata_d = half_sel(m_rdata, half_q);
                    end else if (!we_q) begin
                        d_rdata_d = m_rdata;
                    end
                end else if (tmr_expired) begin
                    state_d = RESP;
                    fail    = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Handshake outputs are decoded from the next state so they leave flops.
        m_req_d = (state_d == ACCESS);
        m_we_d  = (state_d == ACCESS) && (gnt_d == GNT_D) && we_d;
        i_ack_d = (state_d == RESP) && (gnt_d == GNT_I);
        d_ack_d = (state_d == RESP) && (gnt_d == GNT_D);
        err_d   = (state_d == RESP) && fail;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= GNT_I;
            last_q    <= GNT_I;
            dw_q      <= '0;
            half_q    <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            dw_q      <= dw_d;
            half_q    <= half_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = dw_q;
    assign m_wdata = wdata_q;
    assign err     = err_q;
    assign busy    = busy_q;

endmodule

// File: doc/polirv_mem_arbiter.md
Name: polirv_mem_arbiter

Overview:
Shares one single-port, 64-bit-wide unified memory between the core's instruction-fetch port and data port. It arbitrates competing requests, sequences each access with a req/ack handshake toward the requesters and a req/ready handshake toward memory, and steers read data back to the winner. A wait-state timeout turns a hung memory into an error response instead of a deadlock. It sits between the datapath's i_mem/d_mem ports and the memory model.

Parameters:
ADDR_BITS, 9, byte-address width of both requester ports; memory doubleword address is ADDR_BITS-3 bits
MAX_WAIT, 15, maximum cycles in ACCESS without m_ready before timeout; range 1..255

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
i_req  in  1  fetch request, held until i_ack
i_addr  in  ADDR_BITS  fetch byte address; bit 2 selects the 32-bit half
i_rdata  out  32  fetched instruction
i_ack  out  1  one-cycle fetch completion
d_req  in  1  data request, held until d_ack
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_BITS  data byte address; must be 8-byte aligned
d_wdata  in  64  write data
d_rdata  out  64  read data
d_ack  out  1  one-cycle data completion
m_req  out  1  memory access strobe, level
m_we  out  1  memory write enable
m_addr  out  ADDR_BITS-3  doubleword address
m_wdata  out  64  memory write data
m_rdata  in  64  memory read data, valid with m_ready
m_ready  in  1  memory completion, sampled only while m_req=1
err  out  1  one-cycle pulse coincident with the failing i_ack or d_ack
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (rst=1 at a rising edge): state IDLE; every output 0; i_rdata and d_rdata 0; wait counter 0; last_grant=I, so the first contested grant goes to D.
- Reset during ACCESS abandons the access: m_req is 0 from the next cycle and no ack is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, arbitration:
  - only d_req set: grant D.
  - only i_req set: grant I.
  - both set: grant the port that is not last_grant (strict alternation).
  - On grant: latch the address (plus we and wdata for D), set grant and last_grant, clear the counter, go to ACCESS.
- Misaligned data request (d_addr[2:0] != 0): when D wins, go straight to RESP with err=1 and no memory access. last_grant still updates.
- ACCESS:
  - m_req=1; m_addr = latched addr[ADDR_BITS-1:3]; m_we = latched d_we for D, 0 for I; m_wdata = latched wdata.
  - m_ready=1: capture data and go to RESP.
    - I: i_rdata = addr[2] ? m_rdata[63:32] : m_rdata[31:0].
    - D read: d_rdata = m_rdata.
    - D write: d_rdata unchanged.
  - No m_ready: counter increments. If m_ready is still 0 when the counter reaches MAX_WAIT, go to RESP with err=1 and leave rdata unchanged. Cycles in ACCESS are therefore capped at MAX_WAIT+1.
- RESP: the granted port's ack=1 for exactly one cycle; err as determined above; m_req=0; next state IDLE.
- Latency: req seen at edge N → m_req high in cycle N+1. m_ready seen at edge M → ack high in cycle M+1, rdata valid in the same cycle and held until that port's next completion. With zero-wait memory (m_ready already high in the first ACCESS cycle): grant edge N, ack in cycle N+2, next grant no earlier than edge N+3.
- Requester rules:
  - A requester deasserts req in its ack cycle; req still high in the following IDLE cycle counts as a new request.
  - Address and data changes after grant are ignored.
  - Dropping req before ack does not cancel the access; the ack is still issued.
- m_ready is ignored in IDLE and RESP.

Decomposition:
- polirv_pkg holds:
  - state enum {IDLE, ACCESS, RESP}.
  - grant encoding GNT_I=0, GNT_D=1.
  - constants DW_OFFSET_BITS=3 and HALF_SEL_BIT=2.
- One sub-module, polirv_wait_timer: clear, enable, expired-at-MAX_WAIT output, width $clog2(MAX_WAIT+1).

Test Plan:
- i_req=1, i_addr=0x014, memory returns 0x11112222_33334444 on the first ACCESS cycle → m_addr=2, i_ack in cycle N+2, i_rdata=0x11112222, err=0.
- d_req=1, d_we=1, d_addr=0x020, d_wdata=0xDEADBEEF_CAFEF00D → m_we=1, m_addr=4, m_wdata matches, d_ack one cycle, d_rdata unchanged.
- i_req and d_req both held across three accesses from reset → grant order D, I, D; no ack ever coincides with m_req=1.
- d_req with d_addr=0x00C → d_ack and err at N+1, m_req never asserted.
- m_ready tied 0, MAX_WAIT=15 → m_req high for exactly 16 cycles, then the requester's ack with err=1.
- rst=1 on the third ACCESS cycle of a fetch → next cycle m_req=0, busy=0, no i_ack; a fresh i_req after reset completes normally.
